// File: rtl/instruction_encoder.sv
// Packs field-level debug commands into 32-bit MIPS words and writes them
// into program memory at an auto-incrementing address, tracking fill and HALT.
module instruction_encoder #(
  parameter int unsigned CANT_BITS_INSTRUCCION              = 32,
  parameter int unsigned CANT_BITS_ADDRESS_REGISTROS        = 5,
  parameter int unsigned CANT_BITS_IMMEDIATE                = 16,
  parameter int unsigned CANT_BITS_INSTRUCTION_INDEX_BRANCH = 26,
  parameter int unsigned CANT_BITS_ADDR_MEM                 = 10
) (
  input  logic                                          i_clock,
  input  logic                                          i_reset,
  input  logic                                          i_valid,
  output logic                                          o_ready,
  input  logic [3:0]                                    i_kind,
  input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0]        i_reg_A,
  input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0]        i_reg_B,
  input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0]        i_reg_W,
  input  logic [CANT_BITS_IMMEDIATE-1:0]                i_immediate,
  input  logic [CANT_BITS_INSTRUCTION_INDEX_BRANCH-1:0] i_instruction_index,
  input  logic                                          i_clear,
  output logic                                          o_write_enable,
  output logic [CANT_BITS_ADDR_MEM-1:0]                 o_address,
  output logic [CANT_BITS_INSTRUCCION-1:0]              o_instruction,
  output logic [CANT_BITS_ADDR_MEM:0]                   o_count,
  output logic                                          o_error,
  output logic                                          o_full,
  output logic                                          o_done
);

  localparam int unsigned AW = CANT_BITS_ADDR_MEM;
  localparam int unsigned CW = CANT_BITS_ADDR_MEM + 1;
  localparam int unsigned IW = CANT_BITS_INSTRUCCION;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] K_SLL  = 4'd0;
  localparam logic [3:0] K_SRL  = 4'd1;
  localparam logic [3:0] K_SRA  = 4'd2;
  localparam logic [3:0] K_JR   = 4'd3;
  localparam logic [3:0] K_JALR = 4'd4;
  localparam logic [3:0] K_BEQ  = 4'd5;
  localparam logic [3:0] K_BNE  = 4'd6;
  localparam logic [3:0] K_J    = 4'd7;
  localparam logic [3:0] K_JAL  = 4'd8;
  localparam logic [3:0] K_HALT = 4'd15;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          halt_q,  halt_d;
  logic          error_q, error_d;

  logic [IW-1:0] enc_c;
  logic          kind_ok_c;

  // Field packing; only the fields each format uses reach the word.
  always_comb begin
    enc_c     = '0;
    kind_ok_c = 1'b1;
    case (i_kind)
      K_SLL:  enc_c = {6'd0, 5'd0, i_reg_B, i_reg_W, i_immediate[4:0], 6'd0};
      K_SRL:  enc_c = {6'd0, 5'd0, i_reg_B, i_reg_W, i_immediate[4:0], 6'd2};
      K_SRA:  enc_c = {6'd0, 5'd0, i_reg_B, i_reg_W, i_immediate[4:0], 6'd3};
      K_JR:   enc_c = {6'd0, i_reg_A, 15'd0, 6'd8};
      K_JALR: enc_c = {6'd0, i_reg_A, 5'd0, i_reg_W, 5'd0, 6'd9};
      K_BEQ:  enc_c = {6'd4, i_reg_A, i_reg_B, i_immediate};
      K_BNE:  enc_c = {6'd5, i_reg_A, i_reg_B, i_immediate};
      K_J:    enc_c = {6'd2, i_instruction_index};
      K_JAL:  enc_c = {6'd3, i_instruction_index};
      K_HALT: enc_c = '1;
      default: kind_ok_c = 1'b0;
    endcase
  end

  // Next-state logic; clear overrides everything including a pending increment.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    instr_d = instr_q;
    halt_d  = halt_q;
    error_d = 1'b0;
    if (i_clear) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            if (kind_ok_c) begin
              instr_d = enc_c;
              halt_d  = (i_kind == K_HALT);
              state_d = ST_WRITE;
            end else begin
              error_d = 1'b1;
            end
          end
        end
        ST_WRITE: begin
          addr_d  = addr_q + AW'(1);
          count_d = count_q + CW'(1);
          if (halt_q)                     state_d = ST_DONE;
          else if (addr_q == {AW{1'b1}})  state_d = ST_FULL;
          else                            state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      instr_q <= '0;
      halt_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      instr_q <= instr_d;
      halt_q  <= halt_d;
      error_q <= error_d;
    end
  end

  assign o_ready        = (state_q == ST_IDLE);
  assign o_write_enable = (state_q == ST_WRITE);
  assign o_full         = (state_q == ST_FULL);
  assign o_done         = (state_q == ST_DONE);
  assign o_address      = addr_q;
  assign o_count        = count_q;
  assign o_instruction  = instr_q;
  assign o_error        = error_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder with a 4-word memory: directed scenarios plus
// random traffic checked every cycle against a transaction-level model.
module tb_instruction_encoder;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [3:0]  kind;
  logic [4:0]  reg_a, reg_b, reg_w;
  logic [15:0] imm;
  logic [25:0] idx;
  logic        clr;
  logic        we;
  logic [AW-1:0] addr;
  logic [31:0] instr;
  logic [AW:0] count;
  logic        err, full, done;

  int total = 0;
  int bad   = 0;

  // model state
  bit          m_busy, m_full, m_done, m_err, m_halt;
  int          m_addr, m_count;
  logic [31:0] m_instr;

  instruction_encoder #(.CANT_BITS_ADDR_MEM(AW)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .o_ready(ready),
    .i_kind(kind), .i_reg_A(reg_a), .i_reg_B(reg_b), .i_reg_W(reg_w),
    .i_immediate(imm), .i_instruction_index(idx), .i_clear(clr),
    .o_write_enable(we), .o_address(addr), .o_instruction(instr),
    .o_count(count), .o_error(err), .o_full(full), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] encode(input logic [3:0] k, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] im, input logic [25:0] ix);
    logic [31:0] r;
    logic [31:0] sh;
    sh = 32'(im) & 32'h1F;
    case (k)
      4'd0: r = (32'(rt) << 16) + (32'(rd) << 11) + (sh << 6);
      4'd1: r = (32'(rt) << 16) + (32'(rd) << 11) + (sh << 6) + 32'd2;
      4'd2: r = (32'(rt) << 16) + (32'(rd) << 11) + (sh << 6) + 32'd3;
      4'd3: r = (32'(rs) << 21) + 32'd8;
      4'd4: r = (32'(rs) << 21) + (32'(rd) << 11) + 32'd9;
      4'd5: r = (32'd4 << 26) + (32'(rs) << 21) + (32'(rt) << 16) + 32'(im);
      4'd6: r = (32'd5 << 26) + (32'(rs) << 21) + (32'(rt) << 16) + 32'(im);
      4'd7: r = (32'd2 << 26) + 32'(ix);
      4'd8: r = (32'd3 << 26) + 32'(ix);
      default: r = 32'hFFFF_FFFF;
    endcase
    return r;
  endfunction

  function automatic bit kind_ok(input logic [3:0] k);
    return (k <= 4'd8) || (k == 4'd15);
  endfunction

  // Transaction-level model: a pending write, a fill pointer and two sticky flags.
  task automatic model_step();
    m_err = 0;
    if (!rst_n) begin
      m_busy = 0; m_full = 0; m_done = 0; m_halt = 0;
      m_addr = 0; m_count = 0; m_instr = '0;
    end else if (clr) begin
      m_busy = 0; m_full = 0; m_done = 0;
      m_addr = 0; m_count = 0;
    end else if (m_busy) begin
      if (m_halt) m_done = 1;
      else if (m_addr == DEPTH - 1) m_full = 1;
      m_addr  = (m_addr + 1) % DEPTH;
      m_count = m_count + 1;
      m_busy  = 0;
    end else if (!m_full && !m_done && valid) begin
      if (kind_ok(kind)) begin
        m_instr = encode(kind, reg_a, reg_b, reg_w, imm, idx);
        m_halt  = (kind == 4'd15);
        m_busy  = 1;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("ready", 32'(ready), 32'(!m_busy && !m_full && !m_done));
    check("we",    32'(we),    32'(m_busy));
    check("addr",  32'(addr),  32'(m_addr));
    check("count", 32'(count), 32'(m_count));
    check("instr", instr,      m_instr);
    check("error", 32'(err),   32'(m_err));
    check("full",  32'(full),  32'(m_full));
    check("done",  32'(done),  32'(m_done));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Present one request for a single edge; returns in the cycle after acceptance.
  task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [15:0] im, input logic [25:0] ix);
    kind = k; reg_a = rs; reg_b = rt; reg_w = rd; imm = im; idx = ix;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; clr = 1'b0; kind = '0;
    reg_a = '0; reg_b = '0; reg_w = '0; imm = '0; idx = '0;
    tick(); tick();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_instr", instr, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single SLL; junk in rs must not leak
    send(4'd0, 5'd9, 5'd2, 5'd3, 16'hFFE4, 26'h3FFFFFF);
    check("sll_word", instr, 32'h0002_1900);
    check("sll_we", 32'(we), 32'd1);
    check("sll_addr", 32'(addr), 32'd0);
    tick();
    check("sll_ready_back", 32'(ready), 32'd1);
    check("sll_count", 32'(count), 32'd1);
    do_clear();

    // Back-to-back words fill the 4-entry memory
    send(4'd5, 5'd1, 5'd2, 5'd0, 16'h0010, 26'd0);
    check("beq_word", instr, 32'h1022_0010);
    tick();
    send(4'd3, 5'd31, 5'd7, 5'd7, 16'h1234, 26'd5);
    check("jr_word", instr, 32'h03E0_0008);
    check("jr_addr", 32'(addr), 32'd1);
    tick();
    send(4'd4, 5'd4, 5'd3, 5'd31, 16'h0, 26'd0);
    check("jalr_word", instr, 32'h0080_F809);
    check("jalr_addr", 32'(addr), 32'd2);
    tick();
    send(4'd8, 5'd1, 5'd1, 5'd31, 16'hFFFF, 26'h40);
    check("jal_word", instr, 32'h0C00_0040);
    check("jal_addr", 32'(addr), 32'd3);
    tick();
    check("full_set", 32'(full), 32'd1);
    check("full_count", 32'(count), 32'd4);
    send(4'd0, 5'd1, 5'd1, 5'd1, 16'h1, 26'd0);
    check("full_no_we", 32'(we), 32'd0);
    do_clear();
    check("full_cleared", 32'(full), 32'd0);

    // Invalid kind
    send(4'd10, 5'd1, 5'd1, 5'd1, 16'h1, 26'd1);
    check("inv_err", 32'(err), 32'd1);
    check("inv_no_we", 32'(we), 32'd0);
    check("inv_ready", 32'(ready), 32'd1);
    tick();
    check("inv_err_gone", 32'(err), 32'd0);
    send(4'd1, 5'd0, 5'd4, 5'd5, 16'h1F, 26'd0);
    check("after_inv_addr", 32'(addr), 32'd0);
    tick();

    // HALT after three words
    send(4'd2, 5'd0, 5'd4, 5'd5, 16'h3, 26'd0); tick();
    send(4'd7, 5'd0, 5'd0, 5'd0, 16'h0, 26'h123); tick();
    send(4'd15, 5'd3, 5'd3, 5'd3, 16'h3, 26'd3);
    check("halt_word", instr, 32'hFFFF_FFFF);
    check("halt_addr", 32'(addr), 32'd3);
    tick();
    check("done_set", 32'(done), 32'd1);
    check("done_ready", 32'(ready), 32'd0);
    send(4'd0, 5'd1, 5'd1, 5'd1, 16'h1, 26'd0);
    check("done_no_we", 32'(we), 32'd0);
    do_clear();
    check("done_clr_count", 32'(count), 32'd0);
    check("done_clr_ready", 32'(ready), 32'd1);

    // Clear during the write cycle
    send(4'd6, 5'd2, 5'd3, 5'd0, 16'h8000, 26'd0);
    check("clrw_we", 32'(we), 32'd1);
    do_clear();
    check("clrw_addr", 32'(addr), 32'd0);
    check("clrw_count", 32'(count), 32'd0);

    // Reset during the write cycle
    send(4'd0, 5'd0, 5'd1, 5'd1, 16'h1, 26'd0);
    rst_n = 1'b0;
    tick();
    check("rstw_we", 32'(we), 32'd0);
    check("rstw_instr", instr, 32'd0);
    rst_n = 1'b1;
    tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      clr   = ($urandom_range(0, 39) == 0);
      valid = ($urandom_range(0, 9) < 7);
      kind  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 14)) :
              ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 8));
      reg_a = 5'($urandom); reg_b = 5'($urandom); reg_w = 5'($urandom);
      imm   = 16'($urandom); idx = 26'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
